fetch_stage: RTL

Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the decode-stage control unit. Holds the program counter and issues word reads to instruction memory over a req/ready handshake. Absorbs memory wait states, decode stalls and execute-stage redirects. Drives the IF/ID pipeline register that feeds `op`/`funct3` decoding.

---
 rtl/rv_pipe_pkg.sv | 18 +
 rtl/if_id_reg.sv | 62 ++++++
 rtl/fetch_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Types and constants shared by the fetch, decode and execute stages of the pipeline.
`timescale 1ns/1ps
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_DRAIN = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load.
`timescale 1ns/1ps
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus4_in,
    input  logic        valid_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d    = NOP_INSTR;
            pc_d       = 32'h0;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
        end else if (!stall) begin
            instr_d    = instr_in;
            pc_d       = pc_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_out    = instr_q;
    assign pc_out       = pc_q;
    assign pc_plus4_out = pc_plus4_q;
    assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ready handshake, one-entry skid buffer and redirect drain.
//   state    | meaning
//   FS_FETCH | request outstanding at PCF
//   FS_DRAIN | finishing a request made stale by a redirect; word is dropped
//   FS_HOLD  | fetched word parked in skid buffer while decode is stalled
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = rv_pipe_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy
);
    import rv_pipe_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    logic         skid_valid_q, skid_valid_d;
    logic [31:0]  tgt_q, tgt_d;

    logic [31:0]  if_instr, if_pc, if_pc_plus4;
    logic         if_valid;
    logic [31:0]  pcf_plus4;
    logic [31:0]  target_al;

    assign pcf_plus4 = pcf_q + 32'd4;
    assign target_al = align_word(PCTargetE);

    // Gated by rst_n so an in-flight request drops the moment reset asserts.
    assign imem_req  = rst_n && (state_q != FS_HOLD);
    assign imem_addr = pcf_q;
    assign FetchBusy = (state_q == FS_DRAIN) || ((state_q == FS_FETCH) && !imem_ready);

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        tgt_d        = tgt_q;
        if_instr     = NOP_INSTR;
        if_pc        = 32'h0;
        if_pc_plus4  = 32'h0;
        if_valid     = 1'b0;

        case (state_q)
            FS_FETCH: begin
                if (PCSrcE) begin
                    if (imem_ready) begin
                        pcf_d = target_al;
                    end else begin
                        tgt_d   = target_al;
                        state_d = FS_DRAIN;
                    end
                end else if (imem_ready) begin
                    pcf_d = pcf_plus4;
                    if (StallD) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pcf_q;
                        skid_valid_d = 1'b1;
                        state_d      = FS_HOLD;
                    end else begin
                        if_instr    = imem_rdata;
                        if_pc       = pcf_q;
                        if_pc_plus4 = pcf_plus4;
                        if_valid    = 1'b1;
                    end
                end
            end
            FS_HOLD: begin
                if (PCSrcE) begin
                    pcf_d        = target_al;
                    skid_valid_d = 1'b0;
                    state_d      = FS_FETCH;
                end else if (!StallD) begin
                    if (skid_valid_q) begin
                        if_instr    = skid_instr_q;
                        if_pc       = skid_pc_q;
                        if_pc_plus4 = skid_pc_q + 32'd4;
                        if_valid    = 1'b1;
                    end
                    skid_valid_d = 1'b0;
                    state_d      = FS_FETCH;
                end
            end
            FS_DRAIN: begin
                if (PCSrcE) begin
                    tgt_d = target_al;
                end
                if (imem_ready) begin
                    pcf_d   = PCSrcE ? target_al : tgt_q;
                    state_d = FS_FETCH;
                end
            end
            default: begin
                state_d = FS_FETCH;
            end
        endcase

        if (FlushD) begin
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FS_FETCH;
            pcf_q        <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            tgt_q        <= 32'h0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            tgt_q        <= tgt_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (FlushD),
        .stall        (StallD),
        .instr_in     (if_instr),
        .pc_in        (if_pc),
        .pc_plus4_in  (if_pc_plus4),
        .valid_in     (if_valid),
        .instr_out    (InstrD),
        .pc_out       (PCD),
        .pc_plus4_out (PCPlus4D),
        .valid_out    (ValidD)
    );

endmodule
